cache_mem_arbiter: RTL and testbench
====================================

# cache_mem_arbiter

Round-robin arbiter sharing the single physical-memory line port between the instruction cache (IF-stage misses) and the data cache (MEM-stage misses and write-backs). Each transaction is latched at grant, driven to physical memory, and answered with a one-cycle response pulse on the granted side. The losing cache sees no response, so the hazard unit keeps that stage stalled until its own turn.

## Interface
- `LINE_W`, default 256: cache line width in bits.
- `ADDR_W`, default 32: line address width in bits.

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `icache_pmem_read`  in  1  I-cache line fill request; held until `icache_pmem_resp`.
- `icache_pmem_address`  in  ADDR_W  I-cache line address.
- `icache_pmem_rdata`  out  LINE_W  fill data; valid when `icache_pmem_resp`=1.
- `icache_pmem_resp`  out  1  one-cycle completion pulse to the I-cache.
- `dcache_pmem_read`  in  1  D-cache line fill request; held until `dcache_pmem_resp`.
- `dcache_pmem_write`  in  1  D-cache write-back request; held until `dcache_pmem_resp`.
- `dcache_pmem_address`  in  ADDR_W  D-cache line address.
- `dcache_pmem_wdata`  in  LINE_W  write-back data.
- `dcache_pmem_rdata`  out  LINE_W  fill data; valid when `dcache_pmem_resp`=1.
- `dcache_pmem_resp`  out  1  one-cycle completion pulse to the D-cache.
- `pmem_read`  out  1  physical memory read strobe.
- `pmem_write`  out  1  physical memory write strobe.
- `pmem_address`  out  ADDR_W  physical memory line address.
- `pmem_wdata`  out  LINE_W  physical memory write data.
- `pmem_rdata`  in  LINE_W  physical memory read data; valid with `pmem_resp`.
- `pmem_resp`  in  1  physical memory completion pulse.

## Operation
- FSM states: IDLE, BUSY_I, BUSY_D, DONE.
- A registered `last_grant` bit (0 = I, 1 = D) drives round-robin arbitration.
- IDLE:
  - Only I requesting: grant I, go to BUSY_I.
  - Only D requesting: grant D, go to BUSY_D.
  - Both requesting: grant the side not equal to `last_grant`.
  - On every grant, update `last_grant` and latch address, operation (read/write) and wdata into internal registers.
- D-side request is `dcache_pmem_read | dcache_pmem_write`. If both are asserted, the arbiter performs a write; this is a protocol error and is flagged by a bench assertion.
- BUSY_I / BUSY_D:
  - `pmem_read`/`pmem_write` are driven from the latched operation.
  - `pmem_address`/`pmem_wdata` are driven from the latched registers and stay stable for the whole transaction, even if requester inputs change.
  - On `pmem_resp`: capture `pmem_rdata` into the granted side's rdata register (reads only), record the granted side, go to DONE.
- DONE:
  - Assert the recorded side's `*_pmem_resp` for exactly this one cycle, with `pmem_read`=`pmem_write`=0.
  - Ignore all requests this cycle, because the requester drops its request on the cycle after resp.
  - Return to IDLE.
- `pmem_resp` in IDLE or DONE is ignored.
- `icache_pmem_rdata`/`dcache_pmem_rdata` hold their last captured value until the next capture for that side.
- `pmem_wdata` for a read transaction is don't-care; the implementation drives the latched value.

## Timing
- Reset (`rst_n`=0, asynchronous): state=IDLE, `last_grant`=0 (so D wins the first tie). All outputs are 0: strobes, resps, `pmem_address`, `pmem_wdata`, both rdata registers.
- Reset mid-transaction aborts immediately; the strobes drop without waiting for `pmem_resp`.
- Request sampled in IDLE at edge N → `pmem_read`/`pmem_write` high from cycle N+1.
- `pmem_resp` sampled at edge M → `*_pmem_resp` high during cycle M+1 only, with rdata valid in that same cycle.
- Best-case turnaround with 1-cycle memory: request → resp in 3 cycles. The next grant can be issued in the cycle after DONE.
- Back-to-back: a request pending when DONE→IDLE is granted on the next edge. The alternating side wins when both are pending.
- Memory strobes are registered outputs, with no combinational path from any requester input to any `pmem_*` output.

## Test plan
- Reset, then I read at 0x0000_0040; memory answers after 4 cycles with line 0xAA..AA → `pmem_read`=1, addr 0x40 for 4 cycles; `icache_pmem_resp` is one pulse carrying 0xAA..AA; `dcache_pmem_resp` stays 0.
- I read and D write (addr 0x100, wdata 0x55..55) asserted in the same cycle from reset → D served first (`pmem_write`, addr 0x100); I granted in the IDLE cycle after D's DONE.
- Both sides hold continuous requests for 6 transactions → grant order D, I, D, I, D, I; no side is ever granted twice in a row while the other waits.
- During BUSY_I, change `icache_pmem_address` from 0x40 to 0x80 → `pmem_address` stays 0x40 until resp.
- Assert `rst_n`=0 mid-BUSY_D → `pmem_write` drops in the same cycle without a clock edge; after release, a new I request is served normally; a stale `pmem_resp` arriving in IDLE produces no resp pulse.
- Spurious `pmem_resp` in IDLE, plus D holding its request one cycle past resp → no extra grant issued in DONE, only a single `dcache_pmem_resp` pulse.

Source files
------------

// File: rtl/cache_mem_arbiter_if.sv
// Bundle between the arbiter, both cache miss ports and the physical line port.
// No state here; the arbiter registers every pmem strobe and response.
interface cache_mem_arbiter_if #(
   parameter int LINE_W = 256,
   parameter int ADDR_W = 32
);
   logic              icache_pmem_read;
   logic [ADDR_W-1:0] icache_pmem_address;
   logic [LINE_W-1:0] icache_pmem_rdata;
   logic              icache_pmem_resp;

   logic              dcache_pmem_read;
   logic              dcache_pmem_write;
   logic [ADDR_W-1:0] dcache_pmem_address;
   logic [LINE_W-1:0] dcache_pmem_wdata;
   logic [LINE_W-1:0] dcache_pmem_rdata;
   logic              dcache_pmem_resp;

   logic              pmem_read;
   logic              pmem_write;
   logic [ADDR_W-1:0] pmem_address;
   logic [LINE_W-1:0] pmem_wdata;
   logic [LINE_W-1:0] pmem_rdata;
   logic              pmem_resp;

   modport slave (
      input  icache_pmem_read, icache_pmem_address,
      output icache_pmem_rdata, icache_pmem_resp,
      input  dcache_pmem_read, dcache_pmem_write, dcache_pmem_address, dcache_pmem_wdata,
      output dcache_pmem_rdata, dcache_pmem_resp,
      output pmem_read, pmem_write, pmem_address, pmem_wdata,
      input  pmem_rdata, pmem_resp
   );

   modport master (
      output icache_pmem_read, icache_pmem_address,
      input  icache_pmem_rdata, icache_pmem_resp,
      output dcache_pmem_read, dcache_pmem_write, dcache_pmem_address, dcache_pmem_wdata,
      input  dcache_pmem_rdata, dcache_pmem_resp,
      input  pmem_read, pmem_write, pmem_address, pmem_wdata,
      output pmem_rdata, pmem_resp
   );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Round-robin sharing of the pmem line port between I-cache and D-cache; strobes one cycle after grant, resp one cycle after pmem_resp.
// Backpressure: the losing side gets no resp and simply keeps its request held until its turn.
module cache_mem_arbiter #(
   parameter int LINE_W = 256,
   parameter int ADDR_W = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   cache_mem_arbiter_if.slave   bus
);
   typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} state_t;

   state_t            state, state_nxt;
   logic              grant_i, grant_d;
   logic              i_req, d_req;
   logic              last_grant;
   logic              op_write;
   logic              resp_side;
   logic [ADDR_W-1:0] addr_q;
   logic [LINE_W-1:0] wdata_q;
   logic [LINE_W-1:0] i_rdata_q;
   logic [LINE_W-1:0] d_rdata_q;

   assign i_req = bus.icache_pmem_read;
   assign d_req = bus.dcache_pmem_read | bus.dcache_pmem_write;

   always_comb begin
      state_nxt = state;
      grant_i   = 1'b0;
      grant_d   = 1'b0;
      case (state)
         IDLE: begin
            if (i_req && d_req) begin
               grant_i = last_grant;
               grant_d = ~last_grant;
            end else begin
               grant_i = i_req;
               grant_d = d_req;
            end
            if (grant_i)      state_nxt = BUSY_I;
            else if (grant_d) state_nxt = BUSY_D;
         end
         BUSY_I, BUSY_D: begin
            if (bus.pmem_resp) state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Transaction is frozen at grant so requester inputs may wander during BUSY.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant <= 1'b0;
         op_write   <= 1'b0;
         resp_side  <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         i_rdata_q  <= '0;
         d_rdata_q  <= '0;
      end else begin
         if (grant_i) begin
            last_grant <= 1'b0;
            op_write   <= 1'b0;
            addr_q     <= bus.icache_pmem_address;
            wdata_q    <= '0;
         end else if (grant_d) begin
            last_grant <= 1'b1;
            op_write   <= bus.dcache_pmem_write;
            addr_q     <= bus.dcache_pmem_address;
            wdata_q    <= bus.dcache_pmem_wdata;
         end
         if (state == BUSY_I && bus.pmem_resp) begin
            i_rdata_q <= bus.pmem_rdata;
            resp_side <= 1'b0;
         end
         if (state == BUSY_D && bus.pmem_resp) begin
            if (!op_write) d_rdata_q <= bus.pmem_rdata;
            resp_side <= 1'b1;
         end
      end
   end

   assign bus.pmem_read         = (state == BUSY_I || state == BUSY_D) && !op_write;
   assign bus.pmem_write        = (state == BUSY_I || state == BUSY_D) &&  op_write;
   assign bus.pmem_address      = addr_q;
   assign bus.pmem_wdata        = wdata_q;
   assign bus.icache_pmem_resp  = (state == DONE) && !resp_side;
   assign bus.dcache_pmem_resp  = (state == DONE) &&  resp_side;
   assign bus.icache_pmem_rdata = i_rdata_q;
   assign bus.dcache_pmem_rdata = d_rdata_q;
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: reset, single I fill, tie, alternation, stability, mid-txn reset, spurious resp.
// Inputs driven 1ns after the rising edge; outputs sampled there too.
module tb_cache_mem_arbiter;
   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   localparam logic [255:0] LINE_AA = {32{8'hAA}};
   localparam logic [255:0] LINE_55 = {32{8'h55}};
   localparam logic [255:0] LINE_BB = {32{8'hBB}};
   localparam logic [255:0] LINE_EE = {32{8'hEE}};
   localparam logic [255:0] LINE_77 = {32{8'h77}};
   localparam logic [255:0] LINE_66 = {32{8'h66}};
   localparam logic [255:0] LINE_12 = {8{32'h1234_5678}};

   cache_mem_arbiter_if #(.LINE_W(256), .ADDR_W(32)) bus ();

   cache_mem_arbiter #(.LINE_W(256), .ADDR_W(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   always @(posedge clk) begin
      if (rst_n) begin
         assert (!(bus.dcache_pmem_read && bus.dcache_pmem_write)) else begin
            failures++;
            $error("FAIL dcache_protocol observed=read&write expected=one_op");
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic checka(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic checkw(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic clear_inputs();
      bus.icache_pmem_read    = 1'b0;
      bus.icache_pmem_address = '0;
      bus.dcache_pmem_read    = 1'b0;
      bus.dcache_pmem_write   = 1'b0;
      bus.dcache_pmem_address = '0;
      bus.dcache_pmem_wdata   = '0;
      bus.pmem_rdata          = '0;
      bus.pmem_resp           = 1'b0;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      clear_inputs();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // Called in the first BUSY cycle; memory answers in the n-th cycle, returns in DONE.
   task automatic mem_txn(input string tag, input logic rd, input logic wr,
                          input logic [31:0] addr, input int n, input logic [255:0] rdata);
      for (int i = 0; i < n; i++) begin
         check1({tag, "_pmem_read"},  bus.pmem_read,  rd);
         check1({tag, "_pmem_write"}, bus.pmem_write, wr);
         checka({tag, "_pmem_addr"},  bus.pmem_address, addr);
         check1({tag, "_no_iresp"},   bus.icache_pmem_resp, 1'b0);
         check1({tag, "_no_dresp"},   bus.dcache_pmem_resp, 1'b0);
         if (i == n - 1) begin
            bus.pmem_resp  = 1'b1;
            bus.pmem_rdata = rdata;
         end
         tick();
      end
      bus.pmem_resp  = 1'b0;
      bus.pmem_rdata = '0;
   endtask

   initial begin
      logic [255:0] line_k;
      logic [255:0] prev_d;
      logic         side_d;
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      clear_inputs();

      // Reset state before the first clock edge.
      #3;
      check1("rst_pmem_read",  bus.pmem_read,  1'b0);
      check1("rst_pmem_write", bus.pmem_write, 1'b0);
      checka("rst_pmem_addr",  bus.pmem_address, 32'h0);
      checkw("rst_pmem_wdata", bus.pmem_wdata, 256'h0);
      check1("rst_iresp",      bus.icache_pmem_resp, 1'b0);
      check1("rst_dresp",      bus.dcache_pmem_resp, 1'b0);
      checkw("rst_irdata",     bus.icache_pmem_rdata, 256'h0);
      checkw("rst_drdata",     bus.dcache_pmem_rdata, 256'h0);

      // Single I fill, 4-cycle memory.
      apply_reset();
      bus.icache_pmem_read    = 1'b1;
      bus.icache_pmem_address = 32'h0000_0040;
      tick();
      mem_txn("t1", 1'b1, 1'b0, 32'h40, 4, LINE_AA);
      check1("t1_done_iresp", bus.icache_pmem_resp, 1'b1);
      checkw("t1_done_irdata", bus.icache_pmem_rdata, LINE_AA);
      check1("t1_done_dresp", bus.dcache_pmem_resp, 1'b0);
      check1("t1_done_read",  bus.pmem_read, 1'b0);
      tick();
      bus.icache_pmem_read = 1'b0;
      check1("t1_idle_iresp", bus.icache_pmem_resp, 1'b0);
      check1("t1_idle_read",  bus.pmem_read, 1'b0);

      // Tie from reset: D write first, then I.
      apply_reset();
      bus.icache_pmem_read    = 1'b1;
      bus.icache_pmem_address = 32'h0000_0200;
      bus.dcache_pmem_write   = 1'b1;
      bus.dcache_pmem_address = 32'h0000_0100;
      bus.dcache_pmem_wdata   = LINE_55;
      tick();
      checkw("t2_wdata", bus.pmem_wdata, LINE_55);
      mem_txn("t2d", 1'b0, 1'b1, 32'h100, 1, LINE_BB);
      check1("t2d_dresp",  bus.dcache_pmem_resp, 1'b1);
      check1("t2d_iresp",  bus.icache_pmem_resp, 1'b0);
      check1("t2d_write",  bus.pmem_write, 1'b0);
      checkw("t2d_drdata_unchanged", bus.dcache_pmem_rdata, 256'h0);
      tick();
      bus.dcache_pmem_write = 1'b0;
      check1("t2_idle_read",  bus.pmem_read, 1'b0);
      check1("t2_idle_dresp", bus.dcache_pmem_resp, 1'b0);
      tick();
      mem_txn("t2i", 1'b1, 1'b0, 32'h200, 1, LINE_BB);
      check1("t2i_iresp", bus.icache_pmem_resp, 1'b1);
      checkw("t2i_irdata", bus.icache_pmem_rdata, LINE_BB);
      tick();
      bus.icache_pmem_read = 1'b0;

      // Continuous requests on both sides: D, I, D, I, D, I.
      bus.icache_pmem_read    = 1'b1;
      bus.icache_pmem_address = 32'h0000_0300;
      bus.dcache_pmem_read    = 1'b1;
      bus.dcache_pmem_address = 32'h0000_0400;
      prev_d = 256'h0;
      for (int k = 0; k < 6; k++) begin
         side_d = (k % 2 == 0);
         line_k = {8{32'hC0DE_0000 | 32'(k)}};
         tick();
         mem_txn($sformatf("t3_%0d", k), 1'b1, 1'b0, side_d ? 32'h400 : 32'h300, 1, line_k);
         check1($sformatf("t3_%0d_dresp", k), bus.dcache_pmem_resp, side_d);
         check1($sformatf("t3_%0d_iresp", k), bus.icache_pmem_resp, !side_d);
         if (side_d) begin
            checkw($sformatf("t3_%0d_drdata", k), bus.dcache_pmem_rdata, line_k);
            prev_d = line_k;
         end else begin
            checkw($sformatf("t3_%0d_irdata", k), bus.icache_pmem_rdata, line_k);
            checkw($sformatf("t3_%0d_drdata_hold", k), bus.dcache_pmem_rdata, prev_d);
         end
         tick();
         check1($sformatf("t3_%0d_idle_read", k), bus.pmem_read, 1'b0);
      end
      bus.icache_pmem_read = 1'b0;
      bus.dcache_pmem_read = 1'b0;

      // Address held stable while the requester changes it mid-transaction.
      tick();
      bus.icache_pmem_read    = 1'b1;
      bus.icache_pmem_address = 32'h0000_0040;
      tick();
      bus.icache_pmem_address = 32'h0000_0080;
      mem_txn("t4", 1'b1, 1'b0, 32'h40, 3, LINE_EE);
      check1("t4_iresp", bus.icache_pmem_resp, 1'b1);
      checkw("t4_irdata", bus.icache_pmem_rdata, LINE_EE);
      tick();
      bus.icache_pmem_read = 1'b0;

      // Asynchronous reset during BUSY_D.
      tick();
      bus.dcache_pmem_write   = 1'b1;
      bus.dcache_pmem_address = 32'h0000_0500;
      bus.dcache_pmem_wdata   = LINE_12;
      tick();
      check1("t5_busy_write", bus.pmem_write, 1'b1);
      checka("t5_busy_addr",  bus.pmem_address, 32'h500);
      #2;
      rst_n = 1'b0;
      #1;
      check1("t5_arst_write", bus.pmem_write, 1'b0);
      checka("t5_arst_addr",  bus.pmem_address, 32'h0);
      checkw("t5_arst_wdata", bus.pmem_wdata, 256'h0);
      checkw("t5_arst_irdata", bus.icache_pmem_rdata, 256'h0);
      check1("t5_arst_dresp", bus.dcache_pmem_resp, 1'b0);
      bus.dcache_pmem_write = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      bus.pmem_resp = 1'b1;
      tick();
      bus.pmem_resp = 1'b0;
      check1("t5_stale_iresp", bus.icache_pmem_resp, 1'b0);
      check1("t5_stale_dresp", bus.dcache_pmem_resp, 1'b0);
      check1("t5_stale_read",  bus.pmem_read, 1'b0);
      check1("t5_stale_write", bus.pmem_write, 1'b0);
      bus.icache_pmem_read    = 1'b1;
      bus.icache_pmem_address = 32'h0000_0600;
      tick();
      mem_txn("t5i", 1'b1, 1'b0, 32'h600, 2, LINE_77);
      check1("t5i_iresp", bus.icache_pmem_resp, 1'b1);
      check1("t5i_dresp", bus.dcache_pmem_resp, 1'b0);
      checkw("t5i_irdata", bus.icache_pmem_rdata, LINE_77);
      tick();
      bus.icache_pmem_read = 1'b0;

      // Spurious resp in IDLE, then D holds its request through DONE.
      bus.pmem_resp = 1'b1;
      tick();
      bus.pmem_resp = 1'b0;
      check1("t6_spur_dresp", bus.dcache_pmem_resp, 1'b0);
      check1("t6_spur_iresp", bus.icache_pmem_resp, 1'b0);
      bus.dcache_pmem_read    = 1'b1;
      bus.dcache_pmem_address = 32'h0000_0700;
      tick();
      mem_txn("t6", 1'b1, 1'b0, 32'h700, 1, LINE_66);
      check1("t6_dresp", bus.dcache_pmem_resp, 1'b1);
      checkw("t6_drdata", bus.dcache_pmem_rdata, LINE_66);
      tick();
      check1("t6_nogrant_read",  bus.pmem_read, 1'b0);
      check1("t6_nogrant_write", bus.pmem_write, 1'b0);
      check1("t6_single_dresp",  bus.dcache_pmem_resp, 1'b0);
      bus.dcache_pmem_read = 1'b0;
      tick();
      check1("t6_after_dresp", bus.dcache_pmem_resp, 1'b0);
      check1("t6_after_read",  bus.pmem_read, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
